// File: rtl/srp16_boot_loader_if.sv
// rtl/srp16_boot_loader_if.sv - byte-stream and memory-write bundle for the SRP16 boot loader
//
// Purpose: groups the loader's byte-input handshake and its memory/core-control
// outputs so the loader and its byte source share one connection.
// Signals:
//   rx_data[7:0]   image byte from the source
//   rx_valid       rx_data valid this cycle
//   rx_ready       loader can take a byte this cycle
//   mem_addr       memory word address for the write
//   mem_wdata      memory write data
//   mem_we         one-cycle write strobe per word
//   core_reset     reset to the SRP16 core
//   done           image loaded, core released
//   error          checksum mismatch (checksum build only)
// Modports: slave = the loader, master = the byte source / memory side.
interface srp16_boot_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_we;
  logic                  core_reset;
  logic                  done;
  logic                  error;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr, mem_wdata, mem_we, core_reset, done, error
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_wdata, mem_we, core_reset, done, error
  );
endinterface

// File: rtl/srp16_boot_loader.sv
// rtl/srp16_boot_loader.sv - streams a little-endian program image into SRP16 memory
//
// Purpose: accepts addr_lo, addr_hi, count_lo, count_hi, then count words as
// lo,hi byte pairs; writes each word to consecutive addresses and keeps the
// core in reset until the whole image has been written.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    srp16_boot_loader_if.slave (rx_data/rx_valid/rx_ready in,
//          mem_addr/mem_wdata/mem_we, core_reset, done, error out)
// Configuration: define SRP16_BOOT_CHECKSUM_EN to require a trailing XOR
// checksum byte; a mismatch parks the loader in ERROR with the core held.
module srp16_boot_loader #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  srp16_boot_loader_if.slave     bus
);

  typedef enum logic [3:0] {
    S_ADDR_LO,
    S_ADDR_HI,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_RUN
`ifdef SRP16_BOOT_CHECKSUM_EN
    , S_CHK,
    S_ERROR
`endif
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           count;
  logic [7:0]            lo_byte;   // low byte of whichever 16-bit field is in flight
  logic                  accept;
  logic [15:0]           hdr_word;

  assign accept   = bus.rx_valid & bus.rx_ready;
  assign hdr_word = {bus.rx_data, lo_byte};

`ifdef SRP16_BOOT_CHECKSUM_EN
  logic [7:0] csum;
`else
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_ADDR_LO;
      addr           <= '0;
      count          <= '0;
      lo_byte        <= '0;
      bus.rx_ready   <= 1'b1;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.core_reset <= 1'b1;
      bus.done       <= 1'b0;
`ifdef SRP16_BOOT_CHECKSUM_EN
      csum           <= '0;
      bus.error      <= 1'b0;
`endif
    end else begin
      case (state)
        S_WRITE: begin
          bus.mem_we <= 1'b0;
          addr       <= addr + 1'b1;        // wraps modulo 2^ADDR_WIDTH
          count      <= count - 16'd1;
          if (count == 16'd1) begin
`ifdef SRP16_BOOT_CHECKSUM_EN
            state          <= S_CHK;
            bus.rx_ready   <= 1'b1;
`else
            state          <= S_RUN;
            bus.core_reset <= 1'b0;
            bus.done       <= 1'b1;
`endif
          end else begin
            state        <= S_DATA_LO;
            bus.rx_ready <= 1'b1;
          end
        end

        default: begin
          if (accept) begin
`ifdef SRP16_BOOT_CHECKSUM_EN
            // the checksum byte itself is not folded into the running XOR
            if (state != S_CHK) csum <= csum ^ bus.rx_data;
`endif
            case (state)
              S_ADDR_LO: begin
                lo_byte <= bus.rx_data;
                state   <= S_ADDR_HI;
              end
              S_ADDR_HI: begin
                addr  <= ADDR_WIDTH'(hdr_word);
                state <= S_CNT_LO;
              end
              S_CNT_LO: begin
                lo_byte <= bus.rx_data;
                state   <= S_CNT_HI;
              end
              S_CNT_HI: begin
                count <= hdr_word;
                if (hdr_word == 16'd0) begin
`ifdef SRP16_BOOT_CHECKSUM_EN
                  state          <= S_CHK;
`else
                  state          <= S_RUN;
                  bus.rx_ready   <= 1'b0;
                  bus.core_reset <= 1'b0;
                  bus.done       <= 1'b1;
`endif
                end else begin
                  state <= S_DATA_LO;
                end
              end
              S_DATA_LO: begin
                lo_byte <= bus.rx_data;
                state   <= S_DATA_HI;
              end
              S_DATA_HI: begin
                bus.mem_addr  <= addr;
                bus.mem_wdata <= hdr_word;
                bus.mem_we    <= 1'b1;
                bus.rx_ready  <= 1'b0;
                state         <= S_WRITE;
              end
`ifdef SRP16_BOOT_CHECKSUM_EN
              S_CHK: begin
                bus.rx_ready <= 1'b0;
                if (bus.rx_data == csum) begin
                  state          <= S_RUN;
                  bus.core_reset <= 1'b0;
                  bus.done       <= 1'b1;
                end else begin
                  state     <= S_ERROR;
                  bus.error <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srp16_boot_loader.sv
// tb/tb_srp16_boot_loader.sv - self-checking bench for srp16_boot_loader
module tb_srp16_boot_loader;

`ifdef SRP16_BOOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  srp16_boot_loader_if #(.ADDR_WIDTH(16)) bus ();

  srp16_boot_loader #(.ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] cnt;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          bad;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          inv_bad = 0;
  bit          mon_en = 1'b0;
  wr_t         wq[$];
  logic [15:0] wbuf[16];
  vec_t        tbl[4];

  // Captures every write strobe and checks that rx_ready is low exactly
  // when a write is in progress or the loader has finished.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_we === 1'b1) wq.push_back(wr_t'{bus.mem_addr, bus.mem_wdata});
      if (bus.rx_ready !== ~(bus.mem_we | bus.done | bus.error)) inv_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq.delete();
    inv_bad = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t = 0;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: rx_ready got 0 expected 1");
    end
    @(negedge clk);
  endtask

  // Streams header + wbuf[0..cnt-1] (+ checksum) and checks release timing.
  task automatic load_image(input logic [15:0] addr, input logic [15:0] cnt, input bit bad,
                            input int gapmax, input bit exp_done, input bit exp_err);
    logic [7:0] x;
    x = 8'h00;
    send_byte(addr[7:0], $urandom_range(0, gapmax));  x ^= addr[7:0];
    send_byte(addr[15:8], $urandom_range(0, gapmax)); x ^= addr[15:8];
    send_byte(cnt[7:0], $urandom_range(0, gapmax));   x ^= cnt[7:0];
    send_byte(cnt[15:8], $urandom_range(0, gapmax));  x ^= cnt[15:8];
    for (int i = 0; i < int'(cnt); i++) begin
      send_byte(wbuf[i][7:0], $urandom_range(0, gapmax));  x ^= wbuf[i][7:0];
      send_byte(wbuf[i][15:8], $urandom_range(0, gapmax)); x ^= wbuf[i][15:8];
    end
    if (CSUM) send_byte(bad ? (x ^ 8'h07) : x, $urandom_range(0, gapmax));
    bus.rx_valid = 1'b0;
    // without a checksum byte the core is released one edge after the last WRITE
    if (exp_done && !CSUM && cnt != 16'd0) begin
      chk_eq("pre_release_done", 32'(bus.done), 32'd0);
      chk_eq("pre_release_we", 32'(bus.mem_we), 32'd1);
      @(negedge clk);
    end
    chk_eq("done", 32'(bus.done), 32'(exp_done));
    chk_eq("error", 32'(bus.error), 32'(exp_err));
    chk_eq("core_reset", 32'(bus.core_reset), 32'(!exp_done));
  endtask

  initial begin
    logic [15:0] r_addr, r_cnt, ea;
    bit          r_bad;
    int          gm, n;

    tbl[0] = '{16'h0100, 16'd2, 16'h1234, 16'h5678, 1'b0, 16'h0100, 16'h0101, 2, 1'b1, 1'b0};
    tbl[1] = '{16'hFFFF, 16'd2, 16'hAAAA, 16'hBBBB, 1'b0, 16'hFFFF, 16'h0000, 2, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 1'b0};
    tbl[3] = '{16'h0100, 16'd2, 16'h1234, 16'h5678, 1'b1, 16'h0100, 16'h0101, 2, !CSUM, CSUM};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    chk_eq("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk_eq("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk_eq("rst_done", 32'(bus.done), 32'd0);
    chk_eq("rst_error", 32'(bus.error), 32'd0);

    // table vectors, rx_valid held high continuously
    for (int r = 0; r < 4; r++) begin
      do_reset();
      wbuf[0] = tbl[r].w0;
      wbuf[1] = tbl[r].w1;
      load_image(tbl[r].addr, tbl[r].cnt, tbl[r].bad, 0, tbl[r].exp_done, tbl[r].exp_err);
      bus.rx_data  = 8'hA5;   // bytes after the image must be ignored
      bus.rx_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.rx_valid = 1'b0;
      chk_eq("tbl_nwrites", 32'(wq.size()), 32'(tbl[r].exp_writes));
      if (tbl[r].exp_writes > 0 && wq.size() > 0) begin
        chk_eq("tbl_a0", 32'(wq[0].a), 32'(tbl[r].exp_a0));
        chk_eq("tbl_d0", 32'(wq[0].d), 32'(tbl[r].w0));
      end
      if (tbl[r].exp_writes > 1 && wq.size() > 1) begin
        chk_eq("tbl_a1", 32'(wq[1].a), 32'(tbl[r].exp_a1));
        chk_eq("tbl_d1", 32'(wq[1].d), 32'(tbl[r].w1));
      end
      chk_eq("tbl_done_hold", 32'(bus.done), 32'(tbl[r].exp_done));
      chk_eq("tbl_ready_inv", 32'(inv_bad), 32'd0);
    end

    // reset after DATA_LO of the second word, with a byte offered on the reset edge
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 1);
    reset = 1'b1;
    bus.rx_data  = 8'h44;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    chk_eq("mid_core_reset", 32'(bus.core_reset), 32'd1);
    chk_eq("mid_done", 32'(bus.done), 32'd0);
    chk_eq("mid_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk_eq("mid_mem_we", 32'(bus.mem_we), 32'd0);
    chk_eq("mid_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      chk_eq("mid_a0", 32'(wq[0].a), 32'h0200);
      chk_eq("mid_d0", 32'(wq[0].d), 32'h2211);
    end
    wq.delete();
    wbuf[0] = 16'h9999;
    load_image(16'h0300, 16'd1, 1'b0, 1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk_eq("mid_reload_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      chk_eq("mid_reload_a", 32'(wq[0].a), 32'h0300);
      chk_eq("mid_reload_d", 32'(wq[0].d), 32'h9999);
    end

    // randomized images with rx_valid gaps against an address/word list model
    for (int it = 0; it < 10; it++) begin
      r_addr = ($urandom_range(0, 2) == 0) ? (16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      r_cnt  = 16'($urandom_range(0, 6));
      r_bad  = CSUM && ($urandom_range(0, 3) == 0);
      gm     = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
      do_reset();
      load_image(r_addr, r_cnt, r_bad, gm, !r_bad, r_bad);
      repeat (2) @(negedge clk);
      chk_eq("rnd_nwrites", 32'(wq.size()), 32'(r_cnt));
      n = (wq.size() < int'(r_cnt)) ? wq.size() : int'(r_cnt);
      for (int i = 0; i < n; i++) begin
        ea = r_addr + 16'(i);
        chk_eq("rnd_addr", 32'(wq[i].a), 32'(ea));
        chk_eq("rnd_data", 32'(wq[i].d), 32'(wbuf[i]));
      end
      chk_eq("rnd_ready_inv", 32'(inv_bad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
